// File: rtl/noc_route_pkg.sv
// Shared NoC routing definitions: port indices and the direction encoding.
// Used by the lookahead route-computation stage and its helpers.
package noc_route_pkg;

    localparam int NUM_PORT   = 5;
    localparam int PORT_W     = 0;
    localparam int PORT_E     = 1;
    localparam int PORT_S     = 2;
    localparam int PORT_N     = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic [2:0] {
        DIR_W     = 3'd0,
        DIR_E     = 3'd1,
        DIR_S     = 3'd2,
        DIR_N     = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

endpackage

// File: rtl/route_prod_calc.sv
// Productive-port vector and hop count at the next router (combinational).
// Mesh routing by default; `define TORUS_EN selects minimal torus routing.
module route_prod_calc
    import noc_route_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int SIZE_X  = 8,
    parameter int SIZE_Y  = 8
) (
    input  logic [COORD_W:0]   nxt_x,
    input  logic [COORD_W:0]   nxt_y,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic [NUM_PORT-1:0] prod,
    output logic [COORD_W:0]   hops,
    output logic               err
);

    typedef logic [COORD_W:0] wide_t;

    localparam wide_t SX = wide_t'(SIZE_X);
    localparam wide_t SY = wide_t'(SIZE_Y);

    // Returns {positive, negative, |dst - nxt|} for one axis.
    function automatic logic [COORD_W+2:0] axis(input wide_t dst, input wide_t nxt);
        logic signed [COORD_W:0] d;
        d = $signed(dst - nxt);
        return {d > 0, d < 0, (d < 0) ? wide_t'(-d) : wide_t'(d)};
    endfunction

    logic  xp, xn, yp, yn;
    wide_t xd, yd;

    always_comb begin
        prod = '0;
        hops = '0;
        err  = ({1'b0, dst_x} >= SX) || ({1'b0, dst_y} >= SY);
        {xp, xn, xd} = axis({1'b0, dst_x}, nxt_x);
        {yp, yn, yd} = axis({1'b0, dst_y}, nxt_y);
`ifdef TORUS_EN
        if (xd > SX - xd) begin
            {xp, xn} = {xn, xp};
            xd       = SX - xd;
        end else if (xd == SX - xd) begin
            xp = 1'b1;
            xn = 1'b1;
        end
        if (yd > SY - yd) begin
            {yp, yn} = {yn, yp};
            yd       = SY - yd;
        end else if (yd == SY - yd) begin
            yp = 1'b1;
            yn = 1'b1;
        end
`endif
        if (!err) begin
            prod[PORT_E]     = xp;
            prod[PORT_W]     = xn;
            prod[PORT_N]     = yp;
            prod[PORT_S]     = yn;
            prod[PORT_LOCAL] = (xd == '0) && (yd == '0);
            hops             = xd + yd;
        end
    end

endmodule

// File: rtl/route_comp_pipe.sv
// Lookahead route computation for one output port, behind a 2-entry skid pipe.
// Build with `define TORUS_EN for minimal torus routing instead of mesh.
module route_comp_pipe
    import noc_route_pkg::*;
#(
    parameter int COORD_W = 3,
    parameter int SIZE_X  = 8,
    parameter int SIZE_Y  = 8,
    parameter int OUT_DIR = 3,
    parameter int DATA_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COORD_W-1:0]  cur_x,
    input  logic [COORD_W-1:0]  cur_y,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COORD_W-1:0]  in_dst_x,
    input  logic [COORD_W-1:0]  in_dst_y,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_PORT-1:0] out_prod,
    output logic [COORD_W:0]    out_hops,
    output logic                out_err,
    output logic [DATA_W-1:0]   out_data
);

    typedef logic [COORD_W:0] wide_t;

    localparam dir_e  DIR = dir_e'(OUT_DIR);
    localparam wide_t SX  = wide_t'(SIZE_X);
    localparam wide_t SY  = wide_t'(SIZE_Y);
    localparam int    RW  = NUM_PORT + COORD_W + 1 + 1 + DATA_W;

    wide_t cx, cy, nx, ny;

    // Explicit wrap compares: mesh sizes need not be powers of two.
    always_comb begin
        cx = {1'b0, cur_x};
        cy = {1'b0, cur_y};
        nx = cx;
        ny = cy;
        case (DIR)
            DIR_E: nx = (cx + wide_t'(1) >= SX) ? '0 : cx + wide_t'(1);
            DIR_W: nx = (cx == '0) ? SX - wide_t'(1) : cx - wide_t'(1);
            DIR_N: ny = (cy + wide_t'(1) >= SY) ? '0 : cy + wide_t'(1);
            DIR_S: ny = (cy == '0) ? SY - wide_t'(1) : cy - wide_t'(1);
            default: ;
        endcase
    end

    logic [NUM_PORT-1:0] calc_prod;
    logic [COORD_W:0]    calc_hops;
    logic                calc_err;

    route_prod_calc #(
        .COORD_W (COORD_W),
        .SIZE_X  (SIZE_X),
        .SIZE_Y  (SIZE_Y)
    ) u_calc (
        .nxt_x (nx),
        .nxt_y (ny),
        .dst_x (in_dst_x),
        .dst_y (in_dst_y),
        .prod  (calc_prod),
        .hops  (calc_hops),
        .err   (calc_err)
    );

    logic [RW-1:0] in_res;
    logic [RW-1:0] main_q, main_d, skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_fire;

    assign in_res    = {calc_prod, calc_hops, calc_err, in_data};
    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_valid_q;
    assign {out_prod, out_hops, out_err, out_data} = main_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_d       = in_res;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = in_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

endmodule
